// File: rtl/conv_pkg.sv
// Shared constants for the convolver front end: pixel width, FIFO address width,
// largest kernel size, and the flattened window index helper.
package conv_pkg;

    localparam int WID_LINE  = 16;
    localparam int ADDR_FIFO = 9;
    localparam int K_MAX     = 5;

    function automatic int idx(input int r, input int c);
        return r * K_MAX + c;
    endfunction

endpackage

// File: rtl/lb_row_fifo.sv
// Variable-depth delay line feeding the next window row; depth 0 is a plain wire.
// Entries not yet written since the last clear read as zero.
module lb_row_fifo
    import conv_pkg::*;
#(
    parameter int DATA_W = WID_LINE,
    parameter int ADDR_W = ADDR_FIFO
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              shifting,
    input  logic [ADDR_W-1:0] depth,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] rd_addr;

    // The fill count stands in for clearing the whole memory on reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (shifting) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fill != {ADDR_W{1'b1}})
                fill <= fill + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && shifting)
            mem[wr_ptr] <= din;
    end

    assign rd_addr = wr_ptr - depth;

    always_comb begin
        dout = '0;
        if (depth == '0)
            dout = din;
        else if (fill >= depth)
            dout = mem[rd_addr];
    end

endmodule

// File: rtl/line_buffer_kxk.sv
// Runtime-selectable KxK sliding-window generator: K_MAX shift-register rows chained
// through row-delay FIFOs so each row lags the one above by exactly one image row.
module line_buffer_kxk #(
    parameter int DATA_W = conv_pkg::WID_LINE,
    parameter int K_MAX  = conv_pkg::K_MAX,
    parameter int ADDR_W = conv_pkg::ADDR_FIFO
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             line_buffer_reset,
    input  logic                             shifting,
    input  logic [2:0]                       kernel_size,
    input  logic [ADDR_W-1:0]                row_length,
    input  logic [DATA_W-1:0]                inp,
    output logic [K_MAX*K_MAX*DATA_W-1:0]    win,
    output logic                             win_valid,
    output logic                             row_done,
    output logic                             cfg_err
);

    localparam logic [2:0] KMAX3 = 3'(K_MAX);

    logic [2:0]        k_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] col_cnt;
    logic [2:0]        row_cnt;
    logic [DATA_W-1:0] sr       [K_MAX][K_MAX];
    logic [DATA_W-1:0] tap      [K_MAX-1];
    logic [DATA_W-1:0] fifo_out [K_MAX-1];

    logic              clear;
    logic              illegal;
    logic [2:0]        km1;
    logic [2:0]        tap_col;
    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] len_m1;
    logic [ADDR_W-1:0] fifo_depth;

    assign clear      = !rst || line_buffer_reset;
    assign km1        = k_q - 3'd1;
    assign k_ext      = ADDR_W'(k_q);
    assign len_m1     = len_q - ADDR_W'(1);
    assign illegal    = !k_q[0] || (k_q > KMAX3) || (len_q < k_ext);
    assign fifo_depth = (len_q > k_ext) ? (len_q - k_ext) : '0;
    // An out-of-range k only occurs with cfg_err set; keep the tap index in bounds.
    assign tap_col    = (k_q == 3'd0 || k_q > KMAX3) ? (KMAX3 - 3'd1) : km1;

    always_comb begin
        for (int r = 0; r < K_MAX - 1; r++)
            tap[r] = sr[r][tap_col];
    end

    for (genvar g = 0; g < K_MAX - 1; g++) begin : g_fifo
        lb_row_fifo #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fifo (
            .clk      (clk),
            .clear    (clear),
            .shifting (shifting),
            .depth    (fifo_depth),
            .din      (tap[g]),
            .dout     (fifo_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            if (!rst) begin
                k_q   <= 3'd3;
                len_q <= '0;
            end else begin
                k_q   <= kernel_size;
                len_q <= row_length;
            end
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
            row_done  <= 1'b0;
            cfg_err   <= 1'b0;
            for (int r = 0; r < K_MAX; r++)
                for (int c = 0; c < K_MAX; c++)
                    sr[r][c] <= '0;
        end else begin
            cfg_err   <= illegal;
            win_valid <= shifting && !illegal && (row_cnt == km1) && (col_cnt >= ADDR_W'(km1));
            row_done  <= shifting && !illegal && (col_cnt == len_m1);
            if (shifting) begin
                sr[0][0] <= inp;
                for (int r = 1; r < K_MAX; r++)
                    sr[r][0] <= fifo_out[r-1];
                for (int r = 0; r < K_MAX; r++)
                    for (int c = 1; c < K_MAX; c++)
                        sr[r][c] <= sr[r][c-1];
                if (col_cnt == len_m1) begin
                    col_cnt <= '0;
                    if (row_cnt != km1)
                        row_cnt <= row_cnt + 3'd1;
                end else begin
                    col_cnt <= col_cnt + ADDR_W'(1);
                end
            end
        end
    end

    for (genvar gr = 0; gr < K_MAX; gr++) begin : g_row
        for (genvar gc = 0; gc < K_MAX; gc++) begin : g_col
            assign win[(gr*K_MAX+gc)*DATA_W +: DATA_W] =
                (3'(gr) < k_q && 3'(gc) < k_q) ? sr[gr][gc] : '0;
        end
    end

endmodule

// File: tb/tb_line_buffer_kxk.sv
// Randomized self-checking bench for line_buffer_kxk against a pixel-history model
// in which window element (r,c) is simply the pixel accepted r rows and c columns ago.
module tb_line_buffer_kxk;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int KM = 5;
    localparam int AW = 9;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  line_buffer_reset = 1'b0;
    logic                  shifting = 1'b0;
    logic [2:0]            kernel_size = 3'd3;
    logic [AW-1:0]         row_length = '0;
    logic [DW-1:0]         inp = '0;
    logic [KM*KM*DW-1:0]   win;
    logic                  win_valid;
    logic                  row_done;
    logic                  cfg_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] hist[$];
    int  mk   = 3;
    int  mlen = 0;
    bit  acc  = 0;

    line_buffer_kxk #(.DATA_W(DW), .K_MAX(KM), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .line_buffer_reset (line_buffer_reset),
        .shifting          (shifting),
        .kernel_size       (kernel_size),
        .row_length        (row_length),
        .inp               (inp),
        .win               (win),
        .win_valid         (win_valid),
        .row_done          (row_done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal();
        return (mk % 2 == 1) && (mk <= KM) && (mlen >= mk);
    endfunction

    function automatic logic [KM*KM*DW-1:0] exp_win();
        logic [KM*KM*DW-1:0] w;
        int n, p;
        w = '0;
        n = hist.size() - 1;
        for (int r = 0; r < KM; r++)
            for (int c = 0; c < KM; c++)
                if (r < mk && c < mk) begin
                    p = n - r * mlen - c;
                    if (p >= 0) w[idx(r, c)*DW +: DW] = hist[p];
                end
        return w;
    endfunction

    function automatic bit exp_valid();
        int n;
        if (!acc || !m_legal()) return 1'b0;
        n = hist.size() - 1;
        return (n % mlen >= mk - 1) && (n / mlen >= mk - 1);
    endfunction

    function automatic bit exp_row_done();
        int n;
        if (!acc || !m_legal()) return 1'b0;
        n = hist.size() - 1;
        return (n % mlen == mlen - 1);
    endfunction

    function automatic logic [DW-1:0] elem(input int r, input int c);
        return win[idx(r, c)*DW +: DW];
    endfunction

    // One clock of stimulus; the model only sees what the DUT is told to accept.
    task automatic drive_pixel(input bit sh, input logic [DW-1:0] px, input bit lbr);
        shifting = sh;
        inp = px;
        line_buffer_reset = lbr;
        @(posedge clk);
        #1;
        if (lbr) begin
            hist.delete();
            mk   = int'(kernel_size);
            mlen = int'(row_length);
            acc  = 1'b0;
        end else begin
            acc = sh;
            if (sh) hist.push_back(px);
        end
        shifting = 1'b0;
        line_buffer_reset = 1'b0;
    endtask

    task automatic configure(input int k, input int len);
        kernel_size = 3'(k);
        row_length  = AW'(len);
        drive_pixel(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        shifting = 1'b1;
        inp = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (win !== '0) begin errors++; $display("[TB] FAIL reset_win: got %h expected 0", win); end
        checks++;
        if ({win_valid, row_done, cfg_err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {win_valid, row_done, cfg_err});
        end
        shifting = 1'b0;
        rst = 1'b1;
        hist.delete();
        mk = 3; mlen = 0; acc = 1'b0;
    endtask

    task automatic test_k3_ramp();
        int first = -1;
        int done_q[$];
        configure(3, 8);
        for (int i = 0; i < 32; i++) begin
            drive_pixel(1'b1, DW'(i), 1'b0);
            checks++;
            if (win !== exp_win()) begin errors++; $display("[TB] FAIL k3_win px%0d: got %h expected %h", i, win, exp_win()); end
            checks++;
            if (win_valid !== exp_valid()) begin errors++; $display("[TB] FAIL k3_valid px%0d: got %b expected %b", i, win_valid, exp_valid()); end
            checks++;
            if (row_done !== exp_row_done()) begin errors++; $display("[TB] FAIL k3_row_done px%0d: got %b expected %b", i, row_done, exp_row_done()); end
            if (win_valid && first < 0) begin
                first = i;
                checks++;
                if (elem(0,0) !== 16'd18 || elem(0,2) !== 16'd16 || elem(1,0) !== 16'd10 ||
                    elem(1,2) !== 16'd8 || elem(2,0) !== 16'd2 || elem(2,2) !== 16'd0 || elem(3,0) !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL k3_first_window: got %h expected rows {18,17,16},{10,9,8},{2,1,0}", win);
                end
            end
            if (row_done) done_q.push_back(i);
        end
        checks++;
        if (first !== 18) begin errors++; $display("[TB] FAIL k3_first_valid: got %0d expected 18", first); end
        checks++;
        if (done_q.size() != 4 || done_q[0] != 7 || done_q[1] != 15 || done_q[2] != 23 || done_q[3] != 31) begin
            errors++; $display("[TB] FAIL k3_row_done_seq: got %p expected 7,15,23,31", done_q);
        end
    endtask

    task automatic test_k5_ramp();
        int first = -1;
        configure(5, 10);
        for (int i = 0; i < 60; i++) begin
            drive_pixel(1'b1, DW'(i), 1'b0);
            checks++;
            if (win !== exp_win()) begin errors++; $display("[TB] FAIL k5_win px%0d: got %h expected %h", i, win, exp_win()); end
            checks++;
            if (win_valid !== exp_valid()) begin errors++; $display("[TB] FAIL k5_valid px%0d: got %b expected %b", i, win_valid, exp_valid()); end
            if (win_valid && first < 0) begin
                first = i;
                checks++;
                if (elem(4,4) !== 16'd0 || elem(0,0) !== 16'd44) begin
                    errors++; $display("[TB] FAIL k5_first_window: got w00=%0d w44=%0d expected 44 and 0", elem(0,0), elem(4,4));
                end
            end
            if (i >= 50 && i <= 54) begin
                checks++;
                if (win_valid !== (i == 54)) begin errors++; $display("[TB] FAIL k5_row_edge px%0d: got %b expected %b", i, win_valid, i == 54); end
            end
        end
        checks++;
        if (first !== 44) begin errors++; $display("[TB] FAIL k5_first_valid: got %0d expected 44", first); end
    endtask

    task automatic test_stalls();
        int  seen[$];
        int  px = 0;
        int  cycles = 0;
        logic [KM*KM*DW-1:0] prev;
        bit  stall;
        configure(3, 8);
        prev = win;
        while (px < 32 && cycles < 500) begin
            stall = ($urandom_range(0, 99) < 40);
            cycles++;
            drive_pixel(!stall, DW'(px), 1'b0);
            if (stall) begin
                checks++;
                if (win !== prev || win_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold: got %h/%b expected %h/0", win, win_valid, prev); end
            end else begin
                checks++;
                if (win !== exp_win() || win_valid !== exp_valid()) begin
                    errors++; $display("[TB] FAIL stall_win px%0d: got %h/%b expected %h/%b", px, win, win_valid, exp_win(), exp_valid());
                end
                if (win_valid) begin
                    seen.push_back(px);
                    checks++;
                    if (elem(0,0) !== DW'(px) || elem(1,1) !== DW'(px - 9) || elem(2,2) !== DW'(px - 18)) begin
                        errors++; $display("[TB] FAIL stall_window px%0d: got %h", px, win);
                    end
                end
                px++;
            end
            prev = win;
        end
        checks++;
        if (px < 32) begin errors++; $display("[TB] FAIL stall_timeout: got %0d pixels expected 32", px); end
        checks++;
        if (seen.size() != 12 || seen[0] != 18 || seen[5] != 23 || seen[6] != 26 || seen[11] != 31) begin
            errors++; $display("[TB] FAIL stall_valid_seq: got %p expected 18..23,26..31", seen);
        end
    endtask

    task automatic test_illegal_cfg();
        configure(3, 2);
        drive_pixel(1'b0, '0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_short_row: got %b expected 1", cfg_err); end
        for (int i = 0; i < 50; i++) begin
            drive_pixel(1'b1, DW'($urandom), 1'b0);
            checks++;
            if (win_valid !== 1'b0 || row_done !== 1'b0) begin
                errors++; $display("[TB] FAIL cfg_err_gating px%0d: got %b%b expected 00", i, win_valid, row_done);
            end
        end
        configure(4, 10);
        drive_pixel(1'b0, '0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_even_k: got %b expected 1", cfg_err); end
        configure(7, 20);
        drive_pixel(1'b0, '0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_k_too_big: got %b expected 1", cfg_err); end
        configure(5, 5);
        drive_pixel(1'b0, '0, 1'b0);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_legal_min: got %b expected 0", cfg_err); end
    endtask

    task automatic test_pass_through();
        bit sh;
        configure(1, 4);
        for (int i = 0; i < 24; i++) begin
            sh = ($urandom_range(0, 1) == 1);
            drive_pixel(sh, DW'($urandom), 1'b0);
            checks++;
            if (win_valid !== sh || win !== exp_win()) begin
                errors++; $display("[TB] FAIL k1_pass cyc%0d: got %b/%h expected %b/%h", i, win_valid, win, sh, exp_win());
            end
        end
    endtask

    task automatic test_midframe_reconfig();
        int first = -1;
        configure(3, 8);
        for (int i = 0; i < 30; i++) drive_pixel(1'b1, DW'($urandom), 1'b0);
        kernel_size = 3'd5;
        row_length  = AW'(10);
        drive_pixel(1'b1, 16'h0BAD, 1'b1);
        checks++;
        if (win !== '0 || win_valid !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_clear: got %h/%b expected 0/0", win, win_valid); end
        for (int i = 0; i < 50; i++) begin
            drive_pixel(1'b1, DW'($urandom), 1'b0);
            checks++;
            if (win !== exp_win() || win_valid !== exp_valid()) begin
                errors++; $display("[TB] FAIL reconfig_win px%0d: got %h/%b expected %h/%b", i, win, win_valid, exp_win(), exp_valid());
            end
            if (win_valid && first < 0) first = i;
        end
        checks++;
        if (first !== 44) begin errors++; $display("[TB] FAIL reconfig_first_valid: got %0d expected 44", first); end
    endtask

    initial begin
        test_reset();
        test_k3_ramp();
        test_k5_ramp();
        test_stalls();
        test_illegal_cfg();
        test_pass_through();
        test_midframe_reconfig();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/line_buffer_kxk.md
# line_buffer_kxk

Parametrised sliding-window generator for the convolver. It accepts one pixel per enabled cycle, a raster stream of `row_length` pixels per row. It presents a K×K window whose kernel size is selectable at run time up to `K_MAX`, with a per-pixel `win_valid` qualifier that suppresses warm-up windows and windows that straddle a row boundary. It sits between the input feature-map reader and the MAC array and replaces the fixed 3×3 buffer.

## Interface
- `DATA_W`, default `WID_LINE` (16): pixel width.
- `K_MAX`, default 5: largest supported kernel size; odd, at least 3.
- `ADDR_W`, default `ADDR_FIFO` (9): row-length counter and FIFO address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `line_buffer_reset` in 1: synchronous clear of data and counters; also samples the configuration.
- `shifting` in 1: a pixel is accepted on this cycle.
- `kernel_size` in 3: runtime K; legal values are 1, 3 and 5, and must not exceed `K_MAX`.
- `row_length` in ADDR_W: pixels per row.
- `inp` in DATA_W: input pixel.
- `win` out K_MAX*K_MAX*DATA_W: flattened window. Element (r,c) is at slice index r*K_MAX+c. r=0 is the newest row and c=0 is the newest pixel.
- `win_valid` out 1: `win` holds a complete in-row K×K window.
- `row_done` out 1: one-cycle pulse after the last pixel of a row is accepted.
- `cfg_err` out 1: the latched configuration is illegal.

## Operation
- Configuration: `kernel_size` and `row_length` are latched into `k_q`/`len_q` in any cycle with `line_buffer_reset`=1. Both inputs are ignored at all other times.
- `cfg_err` is set when any of these holds:
  - `k_q` is even or zero;
  - `k_q` > `K_MAX`;
  - `len_q` < `k_q`.
- While `cfg_err` is set, `win_valid` and `row_done` are held at 0 and data still shifts.
- Datapath: K_MAX rows of K_MAX-entry shift registers.
  - Row r+1 is fed from a row-delay FIFO of depth `len_q`-`k_q` (clamped to 0).
  - That FIFO is written from column `k_q`-1 of row r.
  - Total delay per row is therefore `len_q` pixels.
- All registers and FIFOs advance only when `shifting`=1.
- Elements with r ≥ `k_q` or c ≥ `k_q` are driven to zero.
- Counters, all advancing only on accepted pixels:
  - `col_cnt` runs 0..`len_q`-1 and wraps.
  - `row_cnt` increments on wrap and saturates at `k_q`-1.
- `win_valid` is registered. It is 1 in the cycle after an accepted pixel for which `row_cnt` = `k_q`-1 and `col_cnt` ≥ `k_q`-1 held before that pixel's increment. Otherwise it is 0, including every cycle that follows a non-shifting cycle.
- `row_done`: registered, 1 in the cycle after the pixel with `col_cnt` = `len_q`-1 is accepted.
- Priority order: `rst` > `line_buffer_reset` > `shifting`. If `line_buffer_reset` and `shifting` are both high, the pixel is dropped.
- Reset effects (either `rst` low or `line_buffer_reset` high):
  - all window registers and FIFO contents read as 0;
  - counters are cleared;
  - `win_valid`, `row_done` and `cfg_err` are cleared.
- On `rst`: `k_q` = 3 and `len_q` = 0.

## Timing
- One pixel per cycle sustained; no back-pressure.
- Latency from accepted `inp` to its appearance at `win[(0,0)]` is 1 cycle.
- `win_valid` and `row_done` are aligned with the `win` update they qualify.
- Warm-up: the first valid window follows the accepted pixel with index (`k_q`-1)*`len_q`+(`k_q`-1), counting from 0 after reset.
- After each row wrap, the first `k_q`-1 pixels of the row produce no valid window.
- A reset applied mid-frame takes effect on the next edge. A full warm-up is required again afterwards.
- `k_q`=1 degenerates to a pass-through: `win_valid` follows `shifting` delayed by one cycle.

## Structure
- Shared package `conv_pkg` holds `WID_LINE`, `ADDR_FIFO`, `K_MAX` and the window index function idx(r,c) = r*K_MAX+c.
- One sub-module, `lb_row_fifo`: a variable-depth delay line, depth 0..2^ADDR_W-1, advanced by `shifting`, with synchronous clear.
  - Depth 0 means a combinational pass-through.
  - Instantiated K_MAX-1 times.

## Test plan
- Reset: hold `rst` low for 2 cycles with `shifting`=1 and `inp`=0xFFFF. Required: `win` all zero, `win_valid`/`row_done`/`cfg_err` all 0.
- K=3, length 8, `inp`=0,1,2… contiguous:
  - first `win_valid` follows pixel 18, with rows r0={18,17,16}, r1={10,9,8}, r2={2,1,0};
  - unused elements are 0;
  - `row_done` pulses after pixels 7, 15 and 23.
- K=5, length 10, ramp:
  - first valid window follows pixel 44 with `win[(4,4)]`=0;
  - pixels 50–53 produce no valid window; pixel 54 produces one.
- Stalls: repeat the K=3 ramp with `shifting` randomly deasserted (about 40%). Required: the sequence of valid windows is identical to the contiguous run, and `win` holds during stalls.
- Illegal configuration:
  - K=3 with length 2 gives `cfg_err`=1 and no `win_valid` over 50 pixels;
  - K=4 gives `cfg_err`=1.
- Mid-frame reconfiguration: pulse `line_buffer_reset` at pixel 30 of a K=3 run with the inputs set to K=5, length 10. Required: `win` becomes zero, and the first valid window follows pixel 44 of the new count.
